clock_mode_controller: RTL and testbench

Time-keeping sequencer for the digital clock. It consumes the 1 Hz and blink-rate enables produced by the clock dividers and owns the HH:MM:SS registers. A 3-state mode FSM (RUN / SET_HR / SET_MIN) is driven by debounced button pulses. It also re-phases the seconds divider through a clear pulse when the user leaves set mode.

---
 rtl/clock_pkg.sv | 17 +
 rtl/wrap_counter.sv | 45 ++++
 rtl/clock_mode_controller.sv | 173 +++++++++++++++++
 tb/tb_clock_mode_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and field widths for the digital clock time-keeping logic.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam int unsigned SEC_MAX = 60;
  localparam int unsigned MIN_MAX = 60;
  localparam int unsigned HR_W    = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned IDLE_W  = 6;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up/down counter with synchronous clear and a combinational
// carry that flags the MOD-1 -> 0 increment so the next stage can chain
// in the same cycle.
module wrap_counter #(
  parameter int unsigned MOD = 60,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] value_o,
  output logic         carry_c_o
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic [W-1:0] value_q, value_d;

  // Next value: clear wins, inc+dec together hold, otherwise wrap either way.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && !dec_i) begin
      value_d = (value_q == TOP) ? '0 : value_q + W'(1);
    end else if (dec_i && !inc_i) begin
      value_d = (value_q == '0) ? TOP : value_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign carry_c_o = inc_i && !dec_i && !clr_i && (value_q == TOP);
  assign value_o   = value_q;

endmodule

// File: rtl/clock_mode_controller.sv
// Time-keeping sequencer: owns HH:MM:SS, runs the RUN/SET_HR/SET_MIN mode
// FSM from debounced buttons, drives digit blanking and re-phases the
// seconds divider when set mode is left.
module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int unsigned HOURS_MAX   = 24,
  parameter int unsigned SET_TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_blink,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       mode,
  output logic             blink_hr,
  output logic             blink_min,
  output logic             div_clr
);

  mode_e mode_q, mode_d;

  logic              run_c, set_hr_c, set_min_c, in_set_c;
  logic              any_btn_c, adj_up_c, adj_dn_c;
  logic              exit_c, timeout_c;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              blink_phase_q, blink_phase_d;
  logic              blink_hr_q, blink_min_q, div_clr_q;
  logic              sec_carry_c, min_carry_c, hr_carry_unused;

  assign run_c     = (mode_q == MODE_RUN);
  assign set_hr_c  = (mode_q == MODE_SET_HR);
  assign set_min_c = (mode_q == MODE_SET_MIN);
  assign in_set_c  = set_hr_c || set_min_c;
  assign any_btn_c = btn_mode || btn_up || btn_down;
  // btn_mode takes priority over adjustment in the same cycle.
  assign adj_up_c  = btn_up && !btn_mode;
  assign adj_dn_c  = btn_down && !btn_mode;

  // Mode state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode next-state; exit_c marks the RUN exit that clears seconds/divider.
  always_comb begin
    mode_d = mode_q;
    exit_c = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        if (btn_mode) begin
          mode_d = MODE_SET_HR;
        end
      end
      MODE_SET_HR: begin
        if (btn_mode) begin
          mode_d = MODE_SET_MIN;
        end else if (timeout_c) begin
          mode_d = MODE_RUN;
          exit_c = 1'b1;
        end
      end
      MODE_SET_MIN: begin
        if (btn_mode || timeout_c) begin
          mode_d = MODE_RUN;
          exit_c = 1'b1;
        end
      end
      default: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  // Idle seconds in a set state; timeout fires on the tick that reaches SET_TIMEOUT.
  always_comb begin
    idle_d    = '0;
    timeout_c = 1'b0;
    if (in_set_c && !any_btn_c) begin
      if (tick_1hz) begin
        if (idle_q == IDLE_W'(SET_TIMEOUT - 1)) begin
          timeout_c = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end else begin
        idle_d = idle_q;
      end
    end
  end

  // Blink phase: adjusting forces digits visible, otherwise toggle at blink rate.
  always_comb begin
    blink_phase_d = blink_phase_q;
    if (btn_up || btn_down) begin
      blink_phase_d = 1'b0;
    end else if (tick_blink) begin
      blink_phase_d = !blink_phase_q;
    end
  end

  // Idle, blink and divider-clear registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q        <= '0;
      blink_phase_q <= 1'b0;
      blink_hr_q    <= 1'b0;
      blink_min_q   <= 1'b0;
      div_clr_q     <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      blink_phase_q <= blink_phase_d;
      blink_hr_q    <= (mode_d == MODE_SET_HR) && blink_phase_d;
      blink_min_q   <= (mode_d == MODE_SET_MIN) && blink_phase_d;
      div_clr_q     <= exit_c;
    end
  end

  wrap_counter #(
    .MOD (SEC_MAX),
    .W   (SEC_W)
  ) u_sec (
    .clk       (clk),
    .rst_n     (rst),
    .inc_i     (run_c && tick_1hz),
    .dec_i     (1'b0),
    .clr_i     (exit_c),
    .value_o   (seconds),
    .carry_c_o (sec_carry_c)
  );

  wrap_counter #(
    .MOD (MIN_MAX),
    .W   (MIN_W)
  ) u_min (
    .clk       (clk),
    .rst_n     (rst),
    .inc_i     ((run_c && sec_carry_c) || (set_min_c && adj_up_c)),
    .dec_i     (set_min_c && adj_dn_c),
    .clr_i     (1'b0),
    .value_o   (minutes),
    .carry_c_o (min_carry_c)
  );

  // Minute roll-over only reaches the hours while running, never while setting.
  wrap_counter #(
    .MOD (HOURS_MAX),
    .W   (HR_W)
  ) u_hr (
    .clk       (clk),
    .rst_n     (rst),
    .inc_i     ((run_c && min_carry_c) || (set_hr_c && adj_up_c)),
    .dec_i     (set_hr_c && adj_dn_c),
    .clr_i     (1'b0),
    .value_o   (hours),
    .carry_c_o (hr_carry_unused)
  );

  assign mode      = mode_q;
  assign blink_hr  = blink_hr_q;
  assign blink_min = blink_min_q;
  assign div_clr   = div_clr_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller: a 24-hour and a 12-hour instance share
// stimulus; a behavioural model queues expected outputs every cycle, and a
// table of directed vectors adds hand-written expectations.
module tb_clock_mode_controller;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, tick_blink, btn_mode, btn_up, btn_down;
  logic [4:0] hours_a, hours_b;
  logic [5:0] min_a, min_b, sec_a, sec_b;
  logic [1:0] mode_a, mode_b;
  logic       bh_a, bm_a, dc_a, bh_b, bm_b, dc_b;

  always #5 clk = ~clk;

  clock_mode_controller #(.HOURS_MAX(24), .SET_TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_blink(tick_blink),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .hours(hours_a), .minutes(min_a), .seconds(sec_a), .mode(mode_a),
    .blink_hr(bh_a), .blink_min(bm_a), .div_clr(dc_a)
  );

  clock_mode_controller #(.HOURS_MAX(12), .SET_TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_blink(tick_blink),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .hours(hours_b), .minutes(min_b), .seconds(sec_b), .mode(mode_b),
    .blink_hr(bh_b), .blink_min(bm_b), .div_clr(dc_b)
  );

  typedef struct {
    int h; int mi; int s; int md; int idle;
    bit ph; bit bh; bit bm; bit dc;
  } mst_t;

  typedef struct {
    mst_t a;
    mst_t b;
  } exp_t;

  typedef struct {
    bit t; bit b; bit m; bit u; bit d;
    int rep;
    int h; int hb; int mi; int s; int md;
    bit bh; bit bm; bit dc;
  } vec_t;

  mst_t ma, mb;
  exp_t exp_q[$];
  vec_t tbl[26];
  int   errors = 0;
  int   checks = 0;

  // Reference behaviour of one clock for one cycle of inputs.
  function automatic mst_t step(input mst_t st, input int hmax,
                                input bit t, input bit b, input bit m,
                                input bit u, input bit d);
    mst_t n = st;
    bit do_exit = 1'b0;
    n.dc = 1'b0;
    if (u || d) n.ph = 1'b0;
    else if (b) n.ph = !st.ph;
    case (st.md)
      0: begin
        if (t) begin
          n.s = st.s + 1;
          if (n.s == 60) begin
            n.s  = 0;
            n.mi = st.mi + 1;
            if (n.mi == 60) begin
              n.mi = 0;
              n.h  = (st.h + 1) % hmax;
            end
          end
        end
        if (m) begin
          n.md   = 1;
          n.idle = 0;
        end
      end
      1, 2: begin
        if (m) begin
          if (st.md == 1) begin
            n.md   = 2;
            n.idle = 0;
          end else begin
            do_exit = 1'b1;
          end
        end else if (u || d) begin
          n.idle = 0;
          if (u && !d) begin
            if (st.md == 1) n.h = (st.h + 1) % hmax;
            else n.mi = (st.mi + 1) % 60;
          end
          if (d && !u) begin
            if (st.md == 1) n.h = (st.h + hmax - 1) % hmax;
            else n.mi = (st.mi + 59) % 60;
          end
        end else if (t) begin
          n.idle = st.idle + 1;
          if (n.idle == TO) do_exit = 1'b1;
        end
      end
      default: n.md = 0;
    endcase
    if (do_exit) begin
      n.md   = 0;
      n.s    = 0;
      n.dc   = 1'b1;
      n.idle = 0;
    end
    n.bh = (n.md == 1) && n.ph;
    n.bm = (n.md == 2) && n.ph;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic chk_a(input string tag, input mst_t e);
    chk({tag, " A hours"},   int'(hours_a), e.h);
    chk({tag, " A minutes"}, int'(min_a),   e.mi);
    chk({tag, " A seconds"}, int'(sec_a),   e.s);
    chk({tag, " A mode"},    int'(mode_a),  e.md);
    chk({tag, " A blink_hr"},  int'(bh_a),  int'(e.bh));
    chk({tag, " A blink_min"}, int'(bm_a),  int'(e.bm));
    chk({tag, " A div_clr"},   int'(dc_a),  int'(e.dc));
  endtask

  task automatic chk_b(input string tag, input mst_t e);
    chk({tag, " B hours"},   int'(hours_b), e.h);
    chk({tag, " B minutes"}, int'(min_b),   e.mi);
    chk({tag, " B seconds"}, int'(sec_b),   e.s);
    chk({tag, " B mode"},    int'(mode_b),  e.md);
    chk({tag, " B blink_hr"},  int'(bh_b),  int'(e.bh));
    chk({tag, " B blink_min"}, int'(bm_b),  int'(e.bm));
    chk({tag, " B div_clr"},   int'(dc_b),  int'(e.dc));
  endtask

  // One clock of stimulus; expectations queued at drive, compared after the edge.
  task automatic drive(input bit t, input bit b, input bit m, input bit u, input bit d);
    exp_t e;
    @(negedge clk);
    tick_1hz = t; tick_blink = b; btn_mode = m; btn_up = u; btn_down = d;
    ma = step(ma, 24, t, b, m, u, d);
    mb = step(mb, 12, t, b, m, u, d);
    e.a = ma;
    e.b = mb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    tick_1hz = 0; tick_blink = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    if (exp_q.size() == 0) begin
      chk("scoreboard empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk_a("cyc", e.a);
      chk_b("cyc", e.b);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    mst_t z;
    z = '{default: 0};
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    ma = z;
    mb = z;
    chk_a(tag, z);
    chk_b(tag, z);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    tick_1hz = 0; tick_blink = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    ma = '{default: 0};
    mb = '{default: 0};

    //          t b m u d  rep  h  hb mi  s md bh bm dc
    tbl[0]  = '{0,0,1,0,0,   1,  0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0,0,0,0,1,   1, 23,11, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{0,0,1,0,0,   1, 23,11, 0, 0, 2, 0, 0, 0};
    tbl[3]  = '{0,0,0,1,0,  61, 23,11, 1, 0, 2, 0, 0, 0};
    tbl[4]  = '{0,0,1,0,0,   1, 23,11, 1, 0, 0, 0, 0, 1};
    tbl[5]  = '{0,0,0,0,0,   1, 23,11, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0,0,1,0,0,   1, 23,11, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{0,0,1,0,0,   1, 23,11, 1, 0, 2, 0, 0, 0};
    tbl[8]  = '{0,0,0,0,1,   2, 23,11,59, 0, 2, 0, 0, 0};
    tbl[9]  = '{0,0,1,0,0,   1, 23,11,59, 0, 0, 0, 0, 1};
    tbl[10] = '{1,0,0,0,0,  58, 23,11,59,58, 0, 0, 0, 0};
    tbl[11] = '{1,0,0,0,0,   1, 23,11,59,59, 0, 0, 0, 0};
    tbl[12] = '{1,0,0,0,0,   1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0,0,1,0,0,   1,  0, 0, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{0,0,1,0,0,   1,  0, 0, 0, 0, 2, 0, 0, 0};
    tbl[15] = '{0,1,0,0,0,   1,  0, 0, 0, 0, 2, 0, 1, 0};
    tbl[16] = '{0,1,0,0,0,   1,  0, 0, 0, 0, 2, 0, 0, 0};
    tbl[17] = '{0,1,0,0,0,   1,  0, 0, 0, 0, 2, 0, 1, 0};
    tbl[18] = '{0,0,0,1,0,   1,  0, 0, 1, 0, 2, 0, 0, 0};
    tbl[19] = '{0,0,0,1,1,   1,  0, 0, 1, 0, 2, 0, 0, 0};
    tbl[20] = '{0,0,1,0,0,   1,  0, 0, 1, 0, 0, 0, 0, 1};
    tbl[21] = '{1,0,1,0,0,   1,  0, 0, 1, 1, 1, 0, 0, 0};
    tbl[22] = '{1,0,0,0,0,   5,  0, 0, 1, 1, 1, 0, 0, 0};
    tbl[23] = '{0,1,0,0,0,   1,  0, 0, 1, 1, 1, 1, 0, 0};
    tbl[24] = '{0,0,1,0,0,   1,  0, 0, 1, 1, 2, 0, 1, 0};
    tbl[25] = '{0,0,1,0,0,   1,  0, 0, 1, 0, 0, 0, 0, 1};

    // Power-on reset.
    #3;
    rst = 1'b0;
    #1;
    chk("por hours", int'(hours_a), 0);
    chk("por mode", int'(mode_a), 0);
    chk("por div_clr", int'(dc_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Free-running seconds with carry into minutes.
    ticks(61);
    chk("run61 minutes", int'(min_a), 1);
    chk("run61 seconds", int'(sec_a), 1);
    chk("run61 mode", int'(mode_a), 0);

    // Directed vectors: set/adjust, preload, roll-over, blink, simultaneity.
    do_reset("rst2");
    for (int i = 0; i < 26; i++) begin
      for (int r = 0; r < tbl[i].rep; r++)
        drive(tbl[i].t, tbl[i].b, tbl[i].m, tbl[i].u, tbl[i].d);
      chk($sformatf("v%0d hours", i),     int'(hours_a), tbl[i].h);
      chk($sformatf("v%0d hours12", i),   int'(hours_b), tbl[i].hb);
      chk($sformatf("v%0d minutes", i),   int'(min_a),   tbl[i].mi);
      chk($sformatf("v%0d seconds", i),   int'(sec_a),   tbl[i].s);
      chk($sformatf("v%0d mode", i),      int'(mode_a),  tbl[i].md);
      chk($sformatf("v%0d blink_hr", i),  int'(bh_a),    int'(tbl[i].bh));
      chk($sformatf("v%0d blink_min", i), int'(bm_a),    int'(tbl[i].bm));
      chk($sformatf("v%0d div_clr", i),   int'(dc_a),    int'(tbl[i].dc));
    end

    // Idle timeout, plain and restarted by a button press.
    drive(0, 0, 1, 0, 0);
    ticks(TO - 1);
    chk("to29 mode", int'(mode_a), 1);
    ticks(1);
    chk("to30 mode", int'(mode_a), 0);
    chk("to30 div_clr", int'(dc_a), 1);
    chk("to30 seconds", int'(sec_a), 0);
    drive(0, 0, 1, 0, 0);
    ticks(TO - 2);
    drive(0, 0, 0, 1, 0);
    ticks(TO - 1);
    chk("restart29 mode", int'(mode_a), 1);
    ticks(1);
    chk("restart30 mode", int'(mode_a), 0);
    chk("restart30 div_clr", int'(dc_a), 1);
    drive(0, 0, 0, 0, 0);
    chk("restart div_clr one cycle", int'(dc_a), 0);

    // Reset while setting 10:20:33, then resume counting from zero.
    do_reset("rst3");
    ticks(33);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 0);
    chk("pre-rst hours", int'(hours_a), 10);
    chk("pre-rst minutes", int'(min_a), 20);
    chk("pre-rst seconds", int'(sec_a), 33);
    chk("pre-rst mode", int'(mode_a), 2);
    do_reset("rst_midset");
    ticks(1);
    chk("post-rst seconds", int'(sec_a), 1);
    chk("post-rst hours", int'(hours_a), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
